// File: rtl/xdma_dsc_byp_arbiter.sv
// xdma_dsc_byp_arbiter: round-robin arbiter and descriptor sequencer for one
// XDMA descriptor-bypass channel (H2C or C2H; one instance per channel).
//
// Whole-transfer requests from NUM_REQ requesters are granted round-robin.
// Each granted transfer is split into descriptors of at most MAX_CHUNK bytes
// and issued on the bypass load/ready interface.
//
// Ports:
//   axi_aclk, axi_aresetn   user clock, async active-low reset
//   req_valid / req_ready   per-requester handshake (ready one-hot or zero)
//   req_src_addr/dst_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_len / req_ctl       packed byte lengths and descriptor control words
//   dsc_byp_*               descriptor bypass interface toward the xdma core
//   busy                    a transfer is being issued
//   cur_grant               requester currently / last served
//   zero_len_err            one-cycle pulse: zero-length request dropped
//   desc_cnt                descriptors accepted by xdma
//
// Build option: define XDMA_DSC_ARB_STATS_EN to enable the 32-bit wrapping
// desc_cnt counter; otherwise desc_cnt is tied to zero.

module xdma_dsc_byp_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 64,
    parameter int LEN_W     = 28,
    parameter int MAX_CHUNK = 4096
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_src_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_dst_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    input  logic [NUM_REQ*16-1:0]       req_ctl,
    output logic                        dsc_byp_load,
    output logic [ADDR_W-1:0]           dsc_byp_src_addr,
    output logic [ADDR_W-1:0]           dsc_byp_dst_addr,
    output logic [LEN_W-1:0]            dsc_byp_len,
    output logic [15:0]                 dsc_byp_ctl,
    input  logic                        dsc_byp_ready,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  cur_grant,
    output logic                        zero_len_err,
    output logic [31:0]                 desc_cnt
);

    localparam int GW = $clog2(NUM_REQ);
    localparam logic [LEN_W-1:0] CHUNK_MAX = LEN_W'(MAX_CHUNK);
    // stop, completed and EOP only belong on the final descriptor
    localparam logic [15:0] CTL_LAST_MASK = 16'h0013;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [15:0]       ctl_q;
    logic [GW-1:0]     last_grant;
    logic              zl_q;

    logic [GW-1:0]     gnt;
    logic              gnt_vld;
    logic [ADDR_W-1:0] sel_src;
    logic [ADDR_W-1:0] sel_dst;
    logic [LEN_W-1:0]  sel_len;
    logic [15:0]       sel_ctl;
    logic [LEN_W-1:0]  chunk;
    logic              last_chunk;
    logic              hs;

    // first valid requester after the last one granted, wrapping
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!gnt_vld && req_valid[idx]) begin
                gnt     = GW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_src = req_src_addr[int'(gnt)*ADDR_W +: ADDR_W];
        sel_dst = req_dst_addr[int'(gnt)*ADDR_W +: ADDR_W];
        sel_len = req_len[int'(gnt)*LEN_W +: LEN_W];
        sel_ctl = req_ctl[int'(gnt)*16 +: 16];
    end

    always_comb begin
        req_ready = '0;
        if (axi_aresetn && state == IDLE && gnt_vld) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign last_chunk = (rem_q <= CHUNK_MAX);
    assign chunk      = last_chunk ? rem_q : CHUNK_MAX;

    assign dsc_byp_load     = (state == ISSUE);
    assign dsc_byp_src_addr = src_q;
    assign dsc_byp_dst_addr = dst_q;
    assign dsc_byp_len      = chunk;
    assign dsc_byp_ctl      = last_chunk ? ctl_q : (ctl_q & ~CTL_LAST_MASK);
    assign hs               = dsc_byp_load && dsc_byp_ready;
    assign busy             = dsc_byp_load;
    assign zero_len_err     = zl_q;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            ctl_q      <= '0;
            cur_grant  <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            zl_q       <= 1'b0;
        end else begin
            zl_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        src_q      <= sel_src;
                        dst_q      <= sel_dst;
                        rem_q      <= sel_len;
                        ctl_q      <= sel_ctl;
                        cur_grant  <= gnt;
                        last_grant <= gnt;
                        if (sel_len == '0) begin
                            zl_q <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        src_q <= src_q + ADDR_W'(chunk);
                        dst_q <= dst_q + ADDR_W'(chunk);
                        rem_q <= rem_q - chunk;
                        if (last_chunk) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XDMA_DSC_ARB_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt_q <= '0;
        end else if (hs) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign desc_cnt = cnt_q;
`else
    assign desc_cnt = '0;
`endif

endmodule
